// File: rtl/mag_comp_pkg.sv
// Shared types for the bit-serial magnitude comparator.
// Holds FSM states, decision encoding, WIDTH limits and a flag decoder.
package mag_comp_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    EQ = 2'b00,
    GT = 2'b01,
    LT = 2'b10
  } dec_t;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } flags_t;

  // Exactly one flag is set for any decision.
  function automatic flags_t dec_flags(
    input dec_t d
  );
    flags_t f;
    f = '0;
    unique case (1'b1)
      d == GT: f.gt = 1'b1;
      d == LT: f.lt = 1'b1;
      default: f.eq = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mag_comp_bit_step.sv
// One bit-pair step of the comparison decision (combinational).
// Ports: dec, a_bit, b_bit in; dec_next out. Order set by LSB_FIRST_EN.
import mag_comp_pkg::*;

module mag_comp_bit_step (
  input  dec_t dec,
  input  logic a_bit,
  input  logic b_bit,
  output dec_t dec_next
);

  logic differ;

  assign differ = a_bit ^ b_bit;

  always_comb begin
    dec_next = dec;
`ifdef LSB_FIRST_EN
    // Later pairs are more significant:
    // every difference overwrites.
    if (differ) begin
      if (a_bit) dec_next = GT;
      else       dec_next = LT;
    end
`else
    // Earlier pairs are more significant:
    // first difference latches.
    if (differ && dec == EQ) begin
      if (a_bit) dec_next = GT;
      else       dec_next = LT;
    end
`endif
  end

endmodule

// File: rtl/serial_mag_comp.sv
// Bit-serial unsigned magnitude comparator (MSB-first, or LSB_FIRST_EN).
// Ports: clk, rst, start, bit_valid, a_bit, b_bit -> busy, done, flags.
import mag_comp_pkg::*;

module serial_mag_comp #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic both_equal,
  output logic a_greater,
  output logic b_greater
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  dec_t           dec_q, dec_d;
  dec_t           step_dec;
  flags_t         flags_q;
  logic           load;

  mag_comp_bit_step u_step (
    .dec      (dec_q),
    .a_bit    (a_bit),
    .b_bit    (b_bit),
    .dec_next (step_dec)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          dec_d   = EQ;
        end
      end
      SHIFT: begin
        // Restart wins over any bit
        // presented in the same cycle.
        if (start) begin
          cnt_d = '0;
          dec_d = EQ;
        end else if (bit_valid) begin
          dec_d = step_dec;
          if (cnt_q == LAST) begin
            state_d = DONE;
            cnt_d   = '0;
            load    = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dec_q   <= EQ;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
    end
  end

  // Flags include the final bit's
  // contribution via step_dec.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else if (load) begin
      flags_q <= dec_flags(step_dec);
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign both_equal = flags_q.eq;
  assign a_greater  = flags_q.gt;
  assign b_greater  = flags_q.lt;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Scoreboard bench for serial_mag_comp (WIDTH=4).
// Integer-compare reference; monitor checks flags and done timing.
module tb_serial_mag_comp;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic bit_valid;
  logic a_bit;
  logic b_bit;
  logic busy;
  logic done;
  logic both_equal;
  logic a_greater;
  logic b_greater;

  typedef struct {
    logic [2:0]  flags;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  bit          lsb_first;

  serial_mag_comp #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bit_valid  (bit_valid),
    .a_bit      (a_bit),
    .b_bit      (b_bit),
    .busy       (busy),
    .done       (done),
    .both_equal (both_equal),
    .a_greater  (a_greater),
    .b_greater  (b_greater)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain unsigned compare, {eq,gt,lt}.
  function automatic logic [2:0] ref_flags(
    input int unsigned a,
    input int unsigned b
  );
    if (a == b) return 3'b100;
    if (a > b)  return 3'b010;
    return 3'b001;
  endfunction

  task automatic junk();
    a_bit = 1'($urandom);
    b_bit = 1'($urandom);
  endtask

  // One comparison: optional abort after abort_at bits,
  // optional stall of nstall cycles before bit stall_at.
  task automatic run_cmp(
    input int unsigned a,
    input int unsigned b,
    input int          stall_at,
    input int          nstall,
    input int          abort_at
  );
    int unsigned e0;
    int          ns;
    int          idx;
    exp_t        e;
    start     = 1'b1;
    bit_valid = 1'($urandom);
    junk();
    tick();
    e0    = cyc;
    start = 1'b0;
    if (abort_at > 0) begin
      for (int k = 0; k < abort_at; k++) begin
        bit_valid = 1'b1;
        junk();
        tick();
      end
      start     = 1'b1;
      bit_valid = 1'b1;
      junk();
      tick();
      e0    = cyc;
      start = 1'b0;
    end
    ns = 0;
    for (int i = 0; i < W; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < nstall; s++) begin
          bit_valid = 1'b0;
          junk();
          tick();
          ns++;
          chk("busy_stall", {31'd0, busy}, 32'd1);
        end
      end
      bit_valid = 1'b1;
      idx   = lsb_first ? i : (W - 1 - i);
      a_bit = a[idx];
      b_bit = b[idx];
      if (i == W - 1) begin
        e.flags = ref_flags(a, b);
        e.cyc   = e0 + W + ns;
        exp_q.push_back(e);
      end
      tick();
      if (i < W - 1)
        chk("busy_shift", {31'd0, busy}, 32'd1);
      else
        chk("busy_in_done", {31'd0, busy}, 32'd0);
    end
    // DONE cycle: start/bit_valid must be ignored.
    start     = 1'b1;
    bit_valid = 1'($urandom);
    junk();
    tick();
    start     = 1'b0;
    bit_valid = 1'b0;
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: compare whenever the DUT presents done.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected none (cyc %0d)",
                 cyc);
      end else begin
        e = exp_q.pop_front();
        chk("flags", {29'd0, both_equal, a_greater, b_greater},
            {29'd0, e.flags});
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned ra;
    int unsigned rb;
    int          sa;
`ifdef LSB_FIRST_EN
    lsb_first = 1'b1;
`else
    lsb_first = 1'b0;
`endif
    rst       = 1'b1;
    start     = 1'b0;
    bit_valid = 1'b0;
    a_bit     = 1'b0;
    b_bit     = 1'b0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_flags", {29'd0, both_equal, a_greater, b_greater}, 32'd0);
    rst = 1'b0;
    tick();

    run_cmp(4'b1010, 4'b1001, -1, 0, 0);
    run_cmp(4'b0111, 4'b1000, -1, 0, 0);
    run_cmp(4'b0110, 4'b0110, -1, 0, 0);
    run_cmp(4'b1100, 4'b1011, 2, 3, 0);
    run_cmp(4'b0011, 4'b0011, -1, 0, 2);
    run_cmp(4'b0001, 4'b0010, -1, 0, 0);

    // Asynchronous reset mid-SHIFT.
    start = 1'b1;
    tick();
    start     = 1'b0;
    bit_valid = 1'b1;
    junk();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_flags", {29'd0, both_equal, a_greater, b_greater}, 32'd0);
    bit_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    run_cmp(4'b1110, 4'b1111, 1, 1, 0);

    for (int n = 0; n < 60; n++) begin
      ra = $urandom_range(0, 15);
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, 15);
      sa = ($urandom_range(0, 4) == 0) ? $urandom_range(1, W - 1) : 0;
      run_cmp(ra, rb, $urandom_range(0, W), $urandom_range(0, 3), sa);
      if ($urandom_range(0, 3) == 0) tick();
    end

    tick();
    tick();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_mag_comp.md
# serial_mag_comp

Bit-serial magnitude comparator for the comparison datapath. It accepts two unsigned WIDTH-bit operands, one bit of each per cycle. A small state machine and bit counter accumulate the decision. After the last bit it presents registered equal/greater/less flags with a one-cycle done pulse. It serves links that deliver operands serially instead of in parallel.

## Interface
- WIDTH, 4, operand width in bits; legal range 2..32.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begins a new comparison; carries no operand bit.
- bit_valid  input  1  a_bit/b_bit hold a valid operand bit this cycle.
- a_bit  input  1  current bit of operand A.
- b_bit  input  1  current bit of operand B.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; result flags updated this cycle.
- both_equal  output  1  A == B for the last completed comparison.
- a_greater  output  1  A > B for the last completed comparison.
- b_greater  output  1  B > A for the last completed comparison.

## Operation
- Three states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 → SHIFT; bit counter cleared to 0; decision register set to EQ.
  - bit_valid is ignored.
- SHIFT:
  - Each cycle with bit_valid=1 consumes one bit pair and increments the counter.
  - Default order is MSB-first. The first differing pair sets the decision to GT (a=1, b=0) or LT (a=0, b=1). Once the decision leaves EQ, later bits do not change it.
  - A bit_valid=1 cycle with counter == WIDTH-1 consumes the final bit and moves to DONE.
  - bit_valid=0 stalls; no state change.
  - start=1 aborts and restarts: counter → 0, decision → EQ, and any bit presented that cycle is discarded.
- DONE:
  - Lasts exactly one cycle, then → IDLE.
  - start and bit_valid are ignored in this cycle.
- The result flags load from the final decision on the edge entering DONE (including the last bit's contribution). They then hold until the next DONE.
- Exactly one of both_equal, a_greater, b_greater is high after the first completed comparison.
- Counter width is $clog2(WIDTH) and it never wraps inside one comparison.

## Timing
- Reset values: busy=0, done=0, both_equal=0, a_greater=0, b_greater=0; state IDLE; counter 0; decision EQ.
- Reset is asynchronous. Asserting it mid-SHIFT or in DONE clears all outputs immediately and abandons the comparison.
- Latency with bit_valid continuously high:
  - start sampled at edge 0; bits sampled at edges 1..WIDTH.
  - done and the new flags are visible in the cycle after edge WIDTH, i.e. WIDTH+1 cycles after start.
- Each stall cycle adds one cycle of latency.
- busy is high from the cycle after start is sampled through the last-bit cycle. It is low in DONE.

## Configuration
- LSB_FIRST_EN defined:
  - Bits arrive LSB-first.
  - Every differing pair overwrites the decision, so the last (most significant) differing bit wins.
  - Equal pairs leave the decision unchanged.
- LSB_FIRST_EN undefined: MSB-first with first-difference latching, as in Operation.
- Ports, latency and handshake are identical in both builds.

## Structure
- Package mag_comp_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the 2-bit decision encoding (EQ, GT, LT);
  - the legal WIDTH limits.
- Sub-module mag_comp_bit_step is combinational: (decision, a_bit, b_bit) → next decision. It contains the only order-dependent logic selected by LSB_FIRST_EN.

## Test plan
All scenarios use WIDTH=4.
- MSB-first, A=1010, B=1001, continuous bits → done 5 cycles after start; a_greater=1, others 0.
- A=B=0110 → both_equal=1. Run this right after a b_greater result to confirm the flags update correctly.
- A=0111, B=1000 → b_greater=1: the first bit decides and the later differing bits are ignored.
- A=1100, B=1011 with bit_valid low for 3 cycles after bit 2 → done 8 cycles after start; a_greater=1; busy stays high through the stall.
- start reasserted after 2 bits, then A=0011, B=0011 → single done, both_equal=1, no result from the aborted operands. Separately, assert rst mid-SHIFT → all outputs 0 at once, next start works normally.
- With LSB_FIRST_EN: A=0001, B=0010 sent LSB-first (1,0,0,0 / 0,1,0,0) → b_greater=1.
